traffic_xing_ctrl: RTL and testbench
====================================

Name: traffic_xing_ctrl

Overview:
Parametrised two-direction intersection controller (north-south / east-west) with a pedestrian walk phase, all-red clearance intervals and a flashing-yellow standby mode. It extends the single-lamp-set controller to two conflicting approaches. Every phase duration is a parameter in clock ticks. It sits between the board tick clock and the lamp drivers; all outputs decode from registered state only.

Parameters:
CNT_W, 8, phase timer width; every *_TICKS must be in 1..2^CNT_W-1
GREEN_TICKS, 8, cycles per green phase (each direction)
YELLOW_TICKS, 3, cycles per yellow phase
ALLRED_TICKS, 2, cycles per all-red clearance
WALK_TICKS, 5, cycles of pedestrian walk phase
FLASH_TICKS, 4, half-period of standby yellow flash in cycles

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
on  in  1  1 = run the cycle, 0 = flashing-yellow standby
ped_req  in  1  pedestrian request, level, sampled on clk
ns_red / ns_yellow / ns_green  out  1 each  north-south lamps
ew_red / ew_yellow / ew_green  out  1 each  east-west lamps
walk  out  1  pedestrian walk lamp
ped_pending  out  1  request latched, not yet served
state_out  out  3  current state code

Behaviour:
- States and codes: OFF=0, ALLRED_A=1, NS_GREEN=2, NS_YELLOW=3, ALLRED_B=4, EW_GREEN=5, EW_YELLOW=6, WALK=7.
- Reset is asynchronous: state=OFF, phase timer=0, flash=0, ped_pending=0, all lamps and walk=0, state_out=0. This takes effect with no clock edge. Reset mid-phase aborts the phase.
- Phase timer: on entry to a timed state it loads duration-1 and decrements each cycle. The state exits on the edge where the timer is 0, so each state lasts exactly its *_TICKS cycles.
- Transitions when on=1:
  - OFF -> ALLRED_A on the next edge.
  - ALLRED_A -> NS_GREEN -> NS_YELLOW -> ALLRED_B -> EW_GREEN -> EW_YELLOW.
  - EW_YELLOW -> WALK if ped_pending=1, else -> ALLRED_A.
  - WALK -> ALLRED_A.
- on=0 in any state: the next edge enters OFF. This has priority over timer expiry. OFF holds while on=0.
- Lamp decode:
  - OFF: reds=0, greens=0, walk=0, ns_yellow=ew_yellow=flash.
  - ALLRED_*: both reds=1.
  - NS_GREEN / NS_YELLOW: ns lamp as named, ew_red=1.
  - EW_GREEN / EW_YELLOW: ew lamp as named, ns_red=1.
  - WALK: both reds=1, walk=1.
  - Exactly one lamp per direction is lit outside OFF. A green on both directions is never permitted.
- Flash: cleared to 0 on every entry to OFF. A separate counter toggles flash every FLASH_TICKS cycles while in OFF. The first toggle to 1 occurs FLASH_TICKS cycles after entry.
- ped_pending:
  - Set on an edge where ped_req=1, on=1, and state is neither OFF nor WALK.
  - Cleared on the transition into WALK and on entry to OFF.
  - Set and clear on the same edge resolve as clear.
  - ped_req held high through WALK re-latches on the first cycle after WALK exits.
- state_out equals the state register; there is no output latency beyond the state register.
- Full cycle without pedestrian: 2*ALLRED + 2*GREEN + 2*YELLOW cycles.

Test Plan:
1. Defaults; reset high 2.5 time units then low; on=0 for 20 cycles -> state_out=0, reds/greens/walk=0, both yellows 0 for 4 cycles, then 1 for 4, alternating.
2. on=1 with ped_req=0 -> state_out runs 1 (2 cycles), 2 (8), 3 (3), 4 (2), 5 (8), 6 (3), then back to 1 (26-cycle period). ns_green and ew_green are never both 1.
3. One-cycle ped_req pulse during NS_GREEN -> ped_pending=1 on the next edge. After EW_YELLOW, state 7 for 5 cycles with walk=1 and both reds=1. ped_pending=0 from WALK entry; then state 1.
4. Drop on=0 during NS_YELLOW -> next edge state_out=0, lamps flash starting at 0. Raise on=1 after 10 cycles -> next edge state_out=1, timing as in test 2.
5. Assert reset mid EW_GREEN between clock edges -> all outputs 0 and state_out=0 immediately. Release reset with on=1 -> OFF then ALLRED_A on the following edge.
6. Hold ped_req=1 continuously -> WALK occurs after every EW_YELLOW. ped_pending=0 during WALK and 1 from the first cycle after each WALK.

Source files
------------

// File: rtl/traffic_xing_if.sv
// Signal bundle between the intersection controller and its driver/lamp side.
// The controller takes the slave modport; the driving side takes master.
`timescale 1ns/1ps
interface traffic_xing_if;
  logic       on;
  logic       ped_req;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state_out;

  modport master (
    output on, ped_req,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
           walk, ped_pending, state_out
  );

  modport slave (
    input  on, ped_req,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
           walk, ped_pending, state_out
  );
endinterface

// File: rtl/traffic_xing_ctrl.sv
// Two-approach intersection controller with pedestrian walk phase, all-red
// clearance and flashing-yellow standby. Lamps are registered from next state.
`timescale 1ns/1ps
module traffic_xing_ctrl #(
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 5,
  parameter int FLASH_TICKS  = 4
) (
  input  logic          clk,
  input  logic          reset,
  traffic_xing_if.slave xif
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    ALLRED_A  = 3'd1,
    NS_GREEN  = 3'd2,
    NS_YELLOW = 3'd3,
    ALLRED_B  = 3'd4,
    EW_GREEN  = 3'd5,
    EW_YELLOW = 3'd6,
    WALK      = 3'd7
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0] flash_cnt_reg, flash_cnt_next;
  logic             flash_reg, flash_next;
  logic             ped_reg, ped_next;
  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  logic [6:0]       lamps_reg, lamps_next;

  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      ALLRED_A, ALLRED_B:   phase_len = CNT_W'(ALLRED_TICKS - 1);
      NS_GREEN, EW_GREEN:   phase_len = CNT_W'(GREEN_TICKS - 1);
      NS_YELLOW, EW_YELLOW: phase_len = CNT_W'(YELLOW_TICKS - 1);
      WALK:                 phase_len = CNT_W'(WALK_TICKS - 1);
      default:              phase_len = '0;
    endcase
  endfunction

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    flash_next     = flash_reg;
    flash_cnt_next = flash_cnt_reg;
    ped_next       = ped_reg;

    if (!xif.on) begin
      state_next = OFF;
      if (state_reg != OFF) begin
        timer_next     = '0;
        flash_next     = 1'b0;
        flash_cnt_next = '0;
      end else if (flash_cnt_reg == CNT_W'(FLASH_TICKS - 1)) begin
        flash_next     = ~flash_reg;
        flash_cnt_next = '0;
      end else begin
        flash_cnt_next = flash_cnt_reg + 1'b1;
      end
    end else if (state_reg == OFF) begin
      state_next = ALLRED_A;
      timer_next = phase_len(ALLRED_A);
    end else if (timer_reg == '0) begin
      case (state_reg)
        ALLRED_A:  state_next = NS_GREEN;
        NS_GREEN:  state_next = NS_YELLOW;
        NS_YELLOW: state_next = ALLRED_B;
        ALLRED_B:  state_next = EW_GREEN;
        EW_GREEN:  state_next = EW_YELLOW;
        EW_YELLOW: state_next = ped_reg ? WALK : ALLRED_A;
        default:   state_next = ALLRED_A;
      endcase
      timer_next = phase_len(state_next);
    end else begin
      timer_next = timer_reg - 1'b1;
    end

    if (xif.ped_req && xif.on && state_reg != OFF && state_reg != WALK)
      ped_next = 1'b1;
    // A request arriving on the same edge as WALK/OFF entry is absorbed.
    if ((state_next == WALK && state_reg != WALK) || state_next == OFF)
      ped_next = 1'b0;

    lamps_next = '0;
    case (state_next)
      OFF:                lamps_next = {1'b0, flash_next, 2'b00, flash_next, 2'b00};
      ALLRED_A, ALLRED_B: lamps_next = 7'b100_100_0;
      NS_GREEN:           lamps_next = 7'b001_100_0;
      NS_YELLOW:          lamps_next = 7'b010_100_0;
      EW_GREEN:           lamps_next = 7'b100_001_0;
      EW_YELLOW:          lamps_next = 7'b100_010_0;
      WALK:               lamps_next = 7'b100_100_1;
      default:            lamps_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= OFF;
      timer_reg     <= '0;
      flash_cnt_reg <= '0;
      flash_reg     <= 1'b0;
      ped_reg       <= 1'b0;
      lamps_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      flash_cnt_reg <= flash_cnt_next;
      flash_reg     <= flash_next;
      ped_reg       <= ped_next;
      lamps_reg     <= lamps_next;
    end
  end

  assign xif.ns_red      = lamps_reg[6];
  assign xif.ns_yellow   = lamps_reg[5];
  assign xif.ns_green    = lamps_reg[4];
  assign xif.ew_red      = lamps_reg[3];
  assign xif.ew_yellow   = lamps_reg[2];
  assign xif.ew_green    = lamps_reg[1];
  assign xif.walk        = lamps_reg[0];
  assign xif.ped_pending = ped_reg;
  assign xif.state_out   = state_reg;

endmodule

// File: tb/tb_traffic_xing_ctrl.sv
// Directed bench for traffic_xing_ctrl: standby flash, full cycle, pedestrian
// service, standby mid-cycle, asynchronous reset and continuous requests.
`timescale 1ns/1ps
module tb_traffic_xing_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  traffic_xing_if xif ();

  traffic_xing_ctrl #(
    .CNT_W(8), .GREEN_TICKS(8), .YELLOW_TICKS(3),
    .ALLRED_TICKS(2), .WALK_TICKS(5), .FLASH_TICKS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .xif  (xif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] lamps();
    return {xif.ns_red, xif.ns_yellow, xif.ns_green,
            xif.ew_red, xif.ew_yellow, xif.ew_green, xif.walk};
  endfunction

  // Expected lamp pattern for each running state code.
  function automatic logic [6:0] exp_lamps(input int code);
    case (code)
      1, 4:    return 7'b100_100_0;
      2:       return 7'b001_100_0;
      3:       return 7'b010_100_0;
      5:       return 7'b100_001_0;
      6:       return 7'b100_010_0;
      7:       return 7'b100_100_1;
      default: return 7'b000_000_0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_phase(input int code, input int dur, input logic ped_first, input logic ped_rest);
    for (int i = 0; i < dur; i++) begin
      step();
      check($sformatf("state s%0d c%0d", code, i), 32'(xif.state_out), 32'(code));
      check($sformatf("lamps s%0d c%0d", code, i), 32'(lamps()), 32'(exp_lamps(code)));
      check($sformatf("ped s%0d c%0d", code, i), 32'(xif.ped_pending),
            32'((i == 0) ? ped_first : ped_rest));
      check($sformatf("dual_green s%0d c%0d", code, i), 32'(xif.ns_green & xif.ew_green), 32'd0);
    end
  endtask

  task automatic full_cycle_no_ped();
    run_phase(1, 2, 1'b0, 1'b0);
    run_phase(2, 8, 1'b0, 1'b0);
    run_phase(3, 3, 1'b0, 1'b0);
    run_phase(4, 2, 1'b0, 1'b0);
    run_phase(5, 8, 1'b0, 1'b0);
    run_phase(6, 3, 1'b0, 1'b0);
  endtask

  initial begin
    logic f;
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    xif.on      = 1'b0;
    xif.ped_req = 1'b0;

    // Reset state before any clock edge
    #1;
    check("reset state", 32'(xif.state_out), 32'd0);
    check("reset lamps", 32'(lamps()), 32'd0);
    check("reset ped", 32'(xif.ped_pending), 32'd0);
    #1.5;
    reset = 1'b0;

    // Test 1: standby flash, 4 cycles dark then 4 lit
    for (int k = 1; k <= 20; k++) begin
      step();
      f = ((k / 4) % 2) == 1;
      check($sformatf("t1 state k%0d", k), 32'(xif.state_out), 32'd0);
      check($sformatf("t1 lamps k%0d", k), 32'(lamps()),
            32'({1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0}));
    end

    // Test 2: two full cycles without pedestrians
    xif.on = 1'b1;
    full_cycle_no_ped();
    full_cycle_no_ped();

    // Test 3: one-cycle request during NS_GREEN
    run_phase(1, 2, 1'b0, 1'b0);
    step();
    check("t3 ns_green entry", 32'(xif.state_out), 32'd2);
    xif.ped_req = 1'b1;
    step();
    xif.ped_req = 1'b0;
    check("t3 latched state", 32'(xif.state_out), 32'd2);
    check("t3 latched ped", 32'(xif.ped_pending), 32'd1);
    run_phase(2, 6, 1'b1, 1'b1);
    run_phase(3, 3, 1'b1, 1'b1);
    run_phase(4, 2, 1'b1, 1'b1);
    run_phase(5, 8, 1'b1, 1'b1);
    run_phase(6, 3, 1'b1, 1'b1);
    run_phase(7, 5, 1'b0, 1'b0);

    // Test 4: standby entered from NS_YELLOW, then resume
    run_phase(1, 2, 1'b0, 1'b0);
    run_phase(2, 8, 1'b0, 1'b0);
    run_phase(3, 1, 1'b0, 1'b0);
    xif.on = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      f = ((j / 4) % 2) == 1;
      check($sformatf("t4 state j%0d", j), 32'(xif.state_out), 32'd0);
      check($sformatf("t4 lamps j%0d", j), 32'(lamps()),
            32'({1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0}));
    end
    xif.on = 1'b1;
    full_cycle_no_ped();

    // Test 5: asynchronous reset mid EW_GREEN
    run_phase(1, 2, 1'b0, 1'b0);
    run_phase(2, 8, 1'b0, 1'b0);
    run_phase(3, 3, 1'b0, 1'b0);
    run_phase(4, 2, 1'b0, 1'b0);
    run_phase(5, 3, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("t5 async state", 32'(xif.state_out), 32'd0);
    check("t5 async lamps", 32'(lamps()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t5 held state", 32'(xif.state_out), 32'd0);
    reset = 1'b0;
    step();
    check("t5 restart state", 32'(xif.state_out), 32'd1);
    check("t5 restart lamps", 32'(lamps()), 32'(exp_lamps(1)));
    check("t5 restart ped", 32'(xif.ped_pending), 32'd0);

    // Test 6: request held high; WALK after every EW_YELLOW
    xif.ped_req = 1'b1;
    run_phase(1, 1, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      run_phase(2, 8, 1'b1, 1'b1);
      run_phase(3, 3, 1'b1, 1'b1);
      run_phase(4, 2, 1'b1, 1'b1);
      run_phase(5, 8, 1'b1, 1'b1);
      run_phase(6, 3, 1'b1, 1'b1);
      run_phase(7, 5, 1'b0, 1'b0);
      run_phase(1, 2, 1'b0, 1'b1);
    end
    xif.ped_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
